// File: rtl/rpsc_power_sequencer.sv
// rtl/rpsc_power_sequencer.sv - RPSC tube supply enable sequencer (standby and HV groups, RF permit)
// Optional build macro RPSC_SEQ_FAULT_LATCH_EN: FAULT is held until i_FAULT_CLR.
module rpsc_power_sequencer #(
    parameter int STEP_CYCLES   = 1000,
    parameter int READY_TIMEOUT = 50000,
    parameter int CNT_W         = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_PS_ON,
    input  logic       i_HV_ON_REQ,
    input  logic       i_Not_ANY_HV_GO_OFF,
    input  logic       i_Not_AN_HV_Ready,
    input  logic       i_FAULT_CLR,
    output logic       o_Not_FAN_ON,
    output logic       o_Not_DR_AMP_ON,
    output logic       o_Not_G1_ON,
    output logic       o_Not_CA_ON,
    output logic       o_Not_G2_ON,
    output logic       o_Not_Anode_ON,
    output logic       o_Not_RF_PERM,
    output logic [3:0] o_state,
    output logic       o_fault
);

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_FAN     = 4'd1,
        ST_DRAMP   = 4'd2,
        ST_G1      = 4'd3,
        ST_CA      = 4'd4,
        ST_STANDBY = 4'd5,
        ST_G2      = 4'd6,
        ST_ANODE   = 4'd7,
        ST_HV_ON   = 4'd8,
        ST_HV_DOWN = 4'd9,
        ST_SB_DOWN = 4'd10,
        ST_FAULT   = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_FULL = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(READY_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fan_q, dr_q, g1_q, ca_q, g2_q, an_q, rf_q, fault_q;
    logic             fan_d, dr_d, g1_d, ca_d, g2_d, an_d, rf_d, fault_d;
    logic [1:0]       abort_sync, ready_sync;
    logic             abort_s, ready_s, dwell_done, sb_step, exit_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_sync <= 2'b11;
            ready_sync <= 2'b11;
        end else begin
            abort_sync <= {abort_sync[0], i_Not_ANY_HV_GO_OFF};
            ready_sync <= {ready_sync[0], i_Not_AN_HV_Ready};
        end
    end

    assign abort_s    = ~abort_sync[1];
    assign ready_s    = ~ready_sync[1];
    assign dwell_done = (cnt_q == STEP_LAST);
    // SB_DOWN releases one rail on the first cycle after entry, then every STEP_CYCLES.
    assign sb_step    = (state_q == ST_SB_DOWN) && ((cnt_q == '0) || (cnt_q == STEP_FULL));

`ifdef RPSC_SEQ_FAULT_LATCH_EN
    assign exit_fault = ~abort_s & i_FAULT_CLR;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = i_FAULT_CLR;
    assign exit_fault       = ~abort_s;
`endif

    always_comb begin
        state_d = state_q;
        fan_d   = fan_q;
        dr_d    = dr_q;
        g1_d    = g1_q;
        ca_d    = ca_q;
        g2_d    = g2_q;
        an_d    = an_q;
        rf_d    = rf_q;
        fault_d = fault_q;

        if (abort_s && (state_q != ST_OFF) && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
            g2_d    = 1'b0;
            an_d    = 1'b0;
            rf_d    = 1'b0;
            fault_d = 1'b1;
        end else if ((state_q == ST_ANODE) && (cnt_q == TO_LAST)) begin
            state_d = ST_FAULT;
            g2_d    = 1'b0;
            an_d    = 1'b0;
            rf_d    = 1'b0;
            fault_d = 1'b1;
        end else if (!i_PS_ON && (state_q inside {ST_FAN, ST_DRAMP, ST_G1, ST_CA, ST_STANDBY,
                                                  ST_G2, ST_ANODE, ST_HV_ON})) begin
            rf_d = 1'b0;
            if (g2_q || an_q) begin
                state_d = ST_HV_DOWN;
                an_d    = 1'b0;
            end else begin
                state_d = ST_SB_DOWN;
            end
        end else if (!i_HV_ON_REQ && (state_q inside {ST_G2, ST_ANODE, ST_HV_ON})) begin
            state_d = ST_HV_DOWN;
            an_d    = 1'b0;
            rf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_OFF:     if (i_PS_ON)     begin state_d = ST_FAN;     fan_d = 1'b1; end
                ST_FAN:     if (dwell_done)  begin state_d = ST_DRAMP;   dr_d  = 1'b1; end
                ST_DRAMP:   if (dwell_done)  begin state_d = ST_G1;      g1_d  = 1'b1; end
                ST_G1:      if (dwell_done)  begin state_d = ST_CA;      ca_d  = 1'b1; end
                ST_CA:      if (dwell_done)  begin state_d = ST_STANDBY;               end
                ST_STANDBY: if (i_HV_ON_REQ) begin state_d = ST_G2;      g2_d  = 1'b1; end
                ST_G2:      if (dwell_done)  begin state_d = ST_ANODE;   an_d  = 1'b1; end
                ST_ANODE:   if (ready_s)     begin state_d = ST_HV_ON;   rf_d  = 1'b1; end
                ST_HV_ON:   ;
                ST_HV_DOWN: if (dwell_done) begin
                    g2_d    = 1'b0;
                    state_d = i_PS_ON ? ST_STANDBY : ST_SB_DOWN;
                end
                ST_SB_DOWN: if (sb_step) begin
                    if (ca_q)      ca_d = 1'b0;
                    else if (g1_q) g1_d = 1'b0;
                    else if (dr_q) dr_d = 1'b0;
                    else begin
                        fan_d   = 1'b0;
                        state_d = ST_OFF;
                    end
                end
                ST_FAULT: if (exit_fault) begin
                    fault_d = 1'b0;
                    state_d = i_PS_ON ? ST_STANDBY : ST_SB_DOWN;
                end
                default: begin
                    state_d = ST_OFF;
                    fan_d   = 1'b0;
                    dr_d    = 1'b0;
                    g1_d    = 1'b0;
                    ca_d    = 1'b0;
                    g2_d    = 1'b0;
                    an_d    = 1'b0;
                    rf_d    = 1'b0;
                    fault_d = 1'b0;
                end
            endcase
        end

        if (state_d != state_q)  cnt_d = '0;
        else if (sb_step)        cnt_d = CNT_W'(1);
        else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
        else                     cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            fan_q   <= 1'b0;
            dr_q    <= 1'b0;
            g1_q    <= 1'b0;
            ca_q    <= 1'b0;
            g2_q    <= 1'b0;
            an_q    <= 1'b0;
            rf_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fan_q   <= fan_d;
            dr_q    <= dr_d;
            g1_q    <= g1_d;
            ca_q    <= ca_d;
            g2_q    <= g2_d;
            an_q    <= an_d;
            rf_q    <= rf_d;
            fault_q <= fault_d;
        end
    end

    assign o_Not_FAN_ON    = ~fan_q;
    assign o_Not_DR_AMP_ON = ~dr_q;
    assign o_Not_G1_ON     = ~g1_q;
    assign o_Not_CA_ON     = ~ca_q;
    assign o_Not_G2_ON     = ~g2_q;
    assign o_Not_Anode_ON  = ~an_q;
    assign o_Not_RF_PERM   = ~rf_q;
    assign o_state         = state_q;
    assign o_fault         = fault_q;

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// tb/tb_rpsc_power_sequencer.sv - scoreboard bench for rpsc_power_sequencer (STEP_CYCLES=4, READY_TIMEOUT=20)
module tb_rpsc_power_sequencer;

    localparam logic [3:0] S_OFF = 4'd0, S_FAN = 4'd1, S_DRAMP = 4'd2, S_G1 = 4'd3, S_CA = 4'd4;
    localparam logic [3:0] S_SB = 4'd5, S_G2 = 4'd6, S_AN = 4'd7, S_HV = 4'd8;
    localparam logic [3:0] S_HVD = 4'd9, S_SBD = 4'd10, S_FLT = 4'd11;
    localparam logic [6:0] FAN = 7'b1000000, DR = 7'b0100000, G1 = 7'b0010000, CA = 7'b0001000;
    localparam logic [6:0] G2 = 7'b0000100, AN = 7'b0000010, RF = 7'b0000001;
    localparam logic [6:0] SBY = 7'b1111000, NONE = 7'b0000000;

    bit   clk;
    logic reset = 1'b1;
    logic ps_on = 1'b0, hv_req = 1'b0, abort_n = 1'b1, ready_n = 1'b1, fault_clr = 1'b0;
    logic n_fan, n_dr, n_g1, n_ca, n_g2, n_an, n_rf, fault;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [11:0] v;
        string       nm;
    } exp_t;
    exp_t exp_q[$];

    rpsc_power_sequencer #(.STEP_CYCLES(4), .READY_TIMEOUT(20), .CNT_W(17)) dut (
        .clk(clk), .reset(reset),
        .i_PS_ON(ps_on), .i_HV_ON_REQ(hv_req),
        .i_Not_ANY_HV_GO_OFF(abort_n), .i_Not_AN_HV_Ready(ready_n), .i_FAULT_CLR(fault_clr),
        .o_Not_FAN_ON(n_fan), .o_Not_DR_AMP_ON(n_dr), .o_Not_G1_ON(n_g1), .o_Not_CA_ON(n_ca),
        .o_Not_G2_ON(n_g2), .o_Not_Anode_ON(n_an), .o_Not_RF_PERM(n_rf),
        .o_state(state), .o_fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ev(input logic [3:0] st, input logic f, input logic [6:0] on);
        return {st, f, ~on};
    endfunction

    task automatic push(input string nm, input int d, input logic [11:0] v);
        exp_t e;
        e.nm  = nm;
        e.cyc = (d < 0) ? -1 : cyc + d;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d events not seen, next %s", nm, exp_q.size(), exp_q[0].nm);
            exp_q.delete();
        end
    endtask

    // Every change of the registered output vector is one DUT event, popped against the queue.
    initial begin
        logic [11:0] cur;
        logic [11:0] prev;
        exp_t        e;
        prev = 'x;
        forever begin
            @(negedge clk or posedge reset);
            #1;
            cur = {state, fault, n_fan, n_dr, n_g1, n_ca, n_g2, n_an, n_rf};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.v) begin
                        errors++;
                        $display("FAIL %s value got=%h exp=%h cyc=%0d", e.nm, cur, e.v, cyc);
                    end
                    if (e.cyc >= 0) begin
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL %s timing got_cyc=%0d exp_cyc=%0d", e.nm, cyc, e.cyc);
                        end
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic power_up();
        @(negedge clk);
        push("fan_on",    1, ev(S_FAN,   1'b0, FAN));
        push("dramp_on",  5, ev(S_DRAMP, 1'b0, FAN | DR));
        push("g1_on",     9, ev(S_G1,    1'b0, FAN | DR | G1));
        push("ca_on",    13, ev(S_CA,    1'b0, SBY));
        push("standby",  17, ev(S_SB,    1'b0, SBY));
        ps_on = 1'b1;
        drain("power_up", 40);
    endtask

    task automatic hv_up();
        @(negedge clk);
        push("g2_on",     1, ev(S_G2, 1'b0, SBY | G2));
        push("anode_on",  5, ev(S_AN, 1'b0, SBY | G2 | AN));
        push("hv_on",    18, ev(S_HV, 1'b0, SBY | G2 | AN | RF));
        hv_req = 1'b1;
        tick(15);
        ready_n = 1'b0;
        drain("hv_up", 40);
    endtask

    initial begin
        push("reset_state", -1, ev(S_OFF, 1'b0, NONE));
        tick(2);
        reset = 1'b0;

        power_up();
        hv_up();

        // Supply drop from HV_ON: full reverse teardown.
        @(negedge clk);
        push("td_hv_down",  1, ev(S_HVD, 1'b0, SBY | G2));
        push("td_g2_off",   5, ev(S_SBD, 1'b0, SBY));
        push("td_ca_off",   6, ev(S_SBD, 1'b0, FAN | DR | G1));
        push("td_g1_off",  10, ev(S_SBD, 1'b0, FAN | DR));
        push("td_dr_off",  14, ev(S_SBD, 1'b0, FAN));
        push("td_off",     18, ev(S_OFF, 1'b0, NONE));
        ps_on = 1'b0;
        drain("teardown", 40);
        hv_req  = 1'b0;
        ready_n = 1'b1;

        power_up();
        hv_up();

        // One-cycle abort pulse in HV_ON; request drop coincides with the abort edge.
        @(negedge clk);
        push("abort_fault", 3, ev(S_FLT, 1'b1, SBY));
`ifndef RPSC_SEQ_FAULT_LATCH_EN
        push("abort_exit",  4, ev(S_SB, 1'b0, SBY));
`endif
        abort_n = 1'b0;
        tick(1);
        abort_n = 1'b1;
        tick(1);
        hv_req = 1'b0;
`ifdef RPSC_SEQ_FAULT_LATCH_EN
        tick(6);
        push("abort_exit", 1, ev(S_SB, 1'b0, SBY));
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
`endif
        drain("abort", 20);
        ready_n = 1'b1;
        tick(4);

        // Ready never arrives: timeout wins over a coincident request drop.
        @(negedge clk);
        push("to_g2_on",     1, ev(S_G2,  1'b0, SBY | G2));
        push("to_anode_on",  5, ev(S_AN,  1'b0, SBY | G2 | AN));
        push("to_fault",    25, ev(S_FLT, 1'b1, SBY));
`ifndef RPSC_SEQ_FAULT_LATCH_EN
        push("to_exit",     26, ev(S_SB,  1'b0, SBY));
`endif
        hv_req = 1'b1;
        tick(24);
        hv_req = 1'b0;
`ifdef RPSC_SEQ_FAULT_LATCH_EN
        tick(6);
        push("to_exit", 1, ev(S_SB, 1'b0, SBY));
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
`endif
        drain("timeout", 50);

        // Supply drop in STANDBY with no HV rail on goes straight to SB_DOWN.
        @(negedge clk);
        push("sb_down",     1, ev(S_SBD, 1'b0, SBY));
        push("sb_ca_off",   2, ev(S_SBD, 1'b0, FAN | DR | G1));
        push("sb_g1_off",   6, ev(S_SBD, 1'b0, FAN | DR));
        push("sb_dr_off",  10, ev(S_SBD, 1'b0, FAN));
        push("sb_off",     14, ev(S_OFF, 1'b0, NONE));
        ps_on = 1'b0;
        drain("sb_drop", 30);

        // Request withdrawn in G1: only FAN, DR_AMP, G1 are released.
        @(negedge clk);
        push("pd_fan_on",    1, ev(S_FAN,   1'b0, FAN));
        push("pd_dramp_on",  5, ev(S_DRAMP, 1'b0, FAN | DR));
        push("pd_g1_on",     9, ev(S_G1,    1'b0, FAN | DR | G1));
        push("pd_sb_down",  11, ev(S_SBD,   1'b0, FAN | DR | G1));
        push("pd_g1_off",   12, ev(S_SBD,   1'b0, FAN | DR));
        push("pd_dr_off",   16, ev(S_SBD,   1'b0, FAN));
        push("pd_off",      20, ev(S_OFF,   1'b0, NONE));
        ps_on = 1'b1;
        tick(10);
        ps_on = 1'b0;
        drain("pre_drop", 40);

        // Asynchronous reset in the middle of ANODE.
        power_up();
        @(negedge clk);
        push("rs_g2_on",    1, ev(S_G2, 1'b0, SBY | G2));
        push("rs_anode_on", 5, ev(S_AN, 1'b0, SBY | G2 | AN));
        hv_req = 1'b1;
        tick(8);
        #2;
        push("async_reset", 0, ev(S_OFF, 1'b0, NONE));
        reset  = 1'b1;
        ps_on  = 1'b0;
        hv_req = 1'b0;
        tick(2);
        reset = 1'b0;
        drain("reset_anode", 10);

        // Abort is ignored in OFF.
        @(negedge clk);
        abort_n = 1'b0;
        tick(2);
        abort_n = 1'b1;
        tick(6);
        drain("off_abort", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
